// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      MUL,
      SIGN,
      DONE
   } state_t;

   localparam int MULT_WIDTH_DEFAULT = 32;

   // Edges from the start-accepting edge until valid/result are visible.
   function automatic int mult_latency(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/valid operand bus shared with the sequential divider.
interface seq_multiplier_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     opera1;
   logic [WIDTH-1:0]     opera2;
   logic [2*WIDTH-1:0]   result;
   logic                 valid;
   logic                 busy;

   modport master (
      output start, opera1, opera2,
      input  result, valid, busy
   );

   modport slave (
      input  start, opera1, opera2,
      output result, valid, busy
   );
endinterface

// File: rtl/seq_multiplier_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and the final sign.
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             neg,
   output logic [WIDTH-1:0] negated
);
   assign negated = neg ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one iteration per clock.
// Define MULT_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   seq_multiplier_if.slave bus
);
`ifdef MULT_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   localparam int CW = $clog2(WIDTH + 1);

   state_t               state;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic                 neg;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     acc;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   result;
   logic                 valid;
   logic                 busy;

   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [2*WIDTH-1:0]   signed_prod;
   logic [WIDTH:0]       sum;

   // Unsigned build forces every negate off, so ABS passes raw operands through.
   cond_negate #(.WIDTH(WIDTH)) u_neg_a (
      .value   (op_a),
      .neg     (SIGNED_EN && op_a[WIDTH-1]),
      .negated (mag_a)
   );

   cond_negate #(.WIDTH(WIDTH)) u_neg_b (
      .value   (op_b),
      .neg     (SIGNED_EN && op_b[WIDTH-1]),
      .negated (mag_b)
   );

   cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
      .value   ({acc, mplier}),
      .neg     (neg),
      .negated (signed_prod)
   );

   // Carry out of the add lands in sum[WIDTH] and shifts into the acc MSB.
   always_comb begin
      sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
   end

   // NOTE: reset is synchronous and clears every register, so an aborted run leaves nothing on result.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         neg    <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         result <= '0;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  op_a  <= bus.opera1;
                  op_b  <= bus.opera2;
                  neg   <= SIGNED_EN && (bus.opera1[WIDTH-1] ^ bus.opera2[WIDTH-1]);
                  valid <= 1'b0;
                  busy  <= 1'b1;
                  state <= ABS;
               end
            end
            ABS: begin
               mcand  <= mag_a;
               mplier <= mag_b;
               acc    <= '0;
               count  <= CW'(WIDTH);
               state  <= MUL;
            end
            MUL: begin
               acc    <= sum[WIDTH:1];
               mplier <= {sum[0], mplier[WIDTH-1:1]};
               count  <= count - CW'(1);
               if (count == CW'(1)) state <= SIGN;
            end
            SIGN: begin
               result <= signed_prod;
               valid  <= 1'b1;
               busy   <= 1'b0;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.result = result;
   assign bus.valid  = valid;
   assign bus.busy   = busy;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier; expectations follow the MULT_SIGNED_EN build option.
module tb_seq_multiplier;
   import mult_pkg::*;

   localparam int WIDTH = 32;
   localparam int LAT   = mult_latency(WIDTH);

`ifdef MULT_SIGNED_EN
   localparam logic [63:0] EXP_MIXED = 64'hFFFFFFFFF4561960;
   localparam logic [63:0] EXP_ONES  = 64'h0000000000000001;
   localparam logic [63:0] EXP_M1X2  = 64'hFFFFFFFFFFFFFFFE;
`else
   localparam logic [63:0] EXP_MIXED = 64'h0001FD97F4561960;
   localparam logic [63:0] EXP_ONES  = 64'hFFFFFFFE00000001;
   localparam logic [63:0] EXP_M1X2  = 64'h00000001FFFFFFFE;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

   seq_multiplier #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          e0    = 0;
   logic [63:0] exp_q[$];
   string       name_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation on each rising valid and checks result stays put while valid.
   logic        prev_valid = 1'b0;
   logic [63:0] held       = '0;
   always @(negedge clock) begin
      if (bus.valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got result %h, expected no result", bus.result);
         end else begin
            check(name_q.pop_front(), bus.result, exp_q.pop_front());
         end
         held = bus.result;
      end else if (bus.valid && prev_valid) begin
         check("result_hold", bus.result, held);
      end
      prev_valid = bus.valid;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input string name, input bit push);
      @(negedge clock);
      bus.start  = 1'b1;
      bus.opera1 = a;
      bus.opera2 = b;
      if (push) begin
         exp_q.push_back(exp);
         name_q.push_back(name);
      end
      @(posedge clock);
      #1;
      e0        = cyc;
      bus.start = 1'b0;
      bus.opera1 = ~a;
      bus.opera2 = ~b;
      check({name, "_valid_drop"}, 64'(bus.valid), 64'd0);
      check({name, "_busy"}, 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.valid && n < 4 * LAT) begin
         @(posedge clock);
         #1;
         n++;
      end
      check({name, "_latency"}, 64'(cyc - e0), 64'(LAT));
      check({name, "_busy_done"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, expected completion");
      $fatal(1);
   end

   initial begin
      bus.start  = 1'b0;
      bus.opera1 = '0;
      bus.opera2 = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_result", bus.result, 64'd0);
      check("rst_valid", 64'(bus.valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clock);
      reset = 1'b1;

      issue(32'd3, 32'd5, 64'h000000000000000F, "mul_3x5", 1'b1);
      wait_valid("mul_3x5");

      issue(32'hFFFFFA24, 32'h0001FD98, EXP_MIXED, "mul_mixed", 1'b1);
      wait_valid("mul_mixed");

      issue(32'h80000000, 32'h80000000, 64'h4000000000000000, "mul_min_sq", 1'b1);
      wait_valid("mul_min_sq");

      issue(32'hFFFFFFFF, 32'hFFFFFFFF, EXP_ONES, "mul_ones", 1'b1);
      wait_valid("mul_ones");

      issue(32'h66666666, 32'h00000000, 64'd0, "mul_zero", 1'b1);
      wait_valid("mul_zero");

      // Restart straight from DONE.
      issue(32'h7FFFFFFF, 32'd2, 64'h00000000FFFFFFFE, "mul_restart", 1'b1);
      wait_valid("mul_restart");

      // A second start mid-run must be ignored.
      issue(32'h00001000, 32'h00000010, 64'h0000000000010000, "mul_ignore", 1'b1);
      repeat (9) @(posedge clock);
      @(negedge clock);
      bus.start  = 1'b1;
      bus.opera1 = 32'hFFFFFFFF;
      bus.opera2 = 32'h12345678;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      wait_valid("mul_ignore");

      // Abort a run with reset at E0+20.
      issue(32'd7, 32'd9, 64'd0, "mul_abort", 1'b0);
      repeat (19) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("abort_result", bus.result, 64'd0);
      check("abort_valid", 64'(bus.valid), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      reset = 1'b1;
      repeat (LAT + 4) @(posedge clock);
      #1;
      check("abort_idle_valid", 64'(bus.valid), 64'd0);
      check("abort_idle_busy", 64'(bus.busy), 64'd0);

      issue(32'hFFFFFFFF, 32'd2, EXP_M1X2, "mul_post_rst", 1'b1);
      wait_valid("mul_post_rst");

      repeat (3) @(posedge clock);
      #1;
      check("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, two's-complement signed.
- Inverse companion of the team's sequential divider; the same arithmetic-unit wrapper selects between the two blocks.
- Uses the same operand naming and the same start/valid handshake as the divider, so the wrapper muxes the two cleanly.
- One shift-add iteration per clock; latency is fixed and does not depend on the data.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock; 0 = reset.
- start  input  1  request; sampled only in IDLE or DONE.
- opera1  input  WIDTH  multiplicand; captured when start is accepted.
- opera2  input  WIDTH  multiplier; captured when start is accepted.
- result  output  2*WIDTH  product; stable while valid=1.
- valid  output  1  result ready; a level, not a pulse.
- busy  output  1  high in ABS, MUL and SIGN.

Behaviour:
- Reset (reset=0 at an edge):
  - result=0, valid=0, busy=0, state=IDLE, internal registers cleared.
  - Takes effect mid-operation too: no partial result ever appears on result.
- States: IDLE, ABS, MUL, SIGN, DONE.
- IDLE:
  - start=1 -> capture opera1/opera2, record neg = opera1[MSB]^opera2[MSB], valid<=0, go to ABS.
  - Otherwise stay.
- ABS:
  - mcand <= |opera1|, mplier <= |opera2|; magnitudes are WIDTH-bit unsigned.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - acc <= 0, count <= WIDTH, go to MUL.
- MUL, once per cycle:
  - If mplier LSB=1, sum = {1'b0,acc} + mcand (WIDTH+1 bits), else sum = {1'b0,acc}.
  - {acc,mplier} <= {sum,mplier} >> 1; the carry of sum shifts into acc MSB.
  - count <= count-1.
  - When count==1, go to SIGN.
- SIGN:
  - result <= neg ? -{acc,mplier} : {acc,mplier}, computed in 2*WIDTH bits with wrap.
  - valid<=1, go to DONE.
- DONE:
  - result and valid held.
  - start=1 is handled exactly as in IDLE: valid drops the next cycle.
- Latency: start sampled at edge E0 -> valid and result visible after edge E0+WIDTH+2. That is 34 edges for WIDTH=32.
- start during ABS, MUL or SIGN is ignored; no queueing.
- Operand changes after capture have no effect.
- Range: the signed product always fits in 2*WIDTH bits, including (-2^(W-1))^2 = 2^(2W-2); there is no overflow flag.
- Zero operands run the full latency; there is no early termination.

Optional Feature:
- MULT_SIGNED_EN.
- Defined: signed behaviour as above.
- Undefined:
  - Operands are unsigned.
  - ABS loads the raw operands and SIGN never negates (neg forced 0).
  - State sequence, latency and ports are identical, so the benches are shared.

Decomposition:
- Package mult_pkg:
  - state enum (IDLE, ABS, MUL, SIGN, DONE);
  - MULT_WIDTH_DEFAULT = 32;
  - MULT_LATENCY = WIDTH+2 helper for benches.
- One sub-module, cond_negate:
  - combinational, parameterised width;
  - out = neg ? ~in+1 : in;
  - one instance for each operand in ABS and one 2*WIDTH instance in SIGN.

Test Plan:
- opera1=3, opera2=5, start for one cycle -> busy for the run; valid=1 exactly 34 edges later; result=64'h000000000000000F.
- opera1=32'hFFFFFA24 (-1500), opera2=32'h0001FD98 (130456) -> result=64'hFFFFFFFFF4561960.
  - Without MULT_SIGNED_EN, the same operands give the unsigned product.
- opera1=opera2=32'h80000000 -> result=64'h4000000000000000.
  - opera1=opera2=32'hFFFFFFFF -> result=64'h0000000000000001 when signed, 64'hFFFFFFFE00000001 without the macro.
- opera1=32'h66666666, opera2=0 -> result=0 after the full latency.
  - Then start again from DONE -> valid drops the next cycle and a new result appears 34 edges later.
- Handshake and reset:
  - Assert start again at E0+10 with different operands -> ignored; first result unchanged.
  - Drive reset=0 at E0+20 -> the next edge gives result=0, valid=0, busy=0, state IDLE.
  - A following start completes normally.
